camera_capture: RTL
===================

CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter BYTES_PER_PIXEL, default 2, meaning bytes per pixel on p_data_in (legal 1 or 2).
REQ-002 Parameter H_ACTIVE, default 640, meaning expected pixels per line.
REQ-003 Parameter V_ACTIVE, default 480, meaning expected lines per frame.
REQ-004 Parameter DECIM, default 1, meaning keep every DECIM-th pixel and line (legal 1, 2, 4).
REQ-005 Parameter SWAP_BYTES, default 0, meaning byte order (0: first byte is MSB; 1: first byte is LSB).
REQ-006 Derived widths: XW = clog2(H_ACTIVE), YW = clog2(V_ACTIVE).
REQ-007 p_clock_in  input  1  pixel clock; all logic on rising edge.
REQ-008 rst_n_in  input  1  reset, synchronous, active-low.
REQ-009 capture_en_in  input  1  permit capture starting at the next frame boundary.
REQ-010 vsync_in  input  1  frame sync; high = vertical blanking.
REQ-011 href_in  input  1  line valid; high = active bytes present.
REQ-012 p_data_in  input  8  camera byte.
REQ-013 pixel_data_out  output  8*BYTES_PER_PIXEL  assembled pixel.
REQ-014 pixel_valid_out  output  1  one-cycle strobe; pixel_data_out, pixel_x_out and pixel_y_out are valid.
REQ-015 pixel_x_out  output  XW  decimated column of the current pixel.
REQ-016 pixel_y_out  output  YW  decimated row of the current pixel.
REQ-017 line_done_out  output  1  one-cycle pulse at the end of each captured line.
REQ-018 frame_done_out  output  1  one-cycle pulse at the end of each captured frame.
REQ-019 frame_error_out  output  1  geometry mismatch on the last frame; held until the next frame starts.
REQ-020 frame_count_out  output  16  number of completed frames; wraps from 0xFFFF to 0.
REQ-021 busy_out  output  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have four states: IDLE, ARM, WAIT_FRAME_START and ROW_CAPTURE.
REQ-023 IDLE -> ARM when capture_en_in=1.
REQ-024 ARM -> WAIT_FRAME_START when vsync_in=1, so capture never begins mid-frame.
REQ-025 WAIT_FRAME_START -> ROW_CAPTURE when vsync_in=0; on this transition the column counter, row counter, byte counter and frame_error_out SHALL clear.
REQ-026 ROW_CAPTURE -> on vsync_in=1: frame_done_out pulses for 1 cycle and frame_count_out increments; next state is WAIT_FRAME_START if capture_en_in=1, otherwise IDLE.
REQ-027 Deasserting capture_en_in mid-frame SHALL NOT abort the frame; the current frame completes normally.
REQ-028 Byte counter, in ROW_CAPTURE: advances on each cycle with href_in=1 and wraps at BYTES_PER_PIXEL; it is forced to 0 whenever href_in=0, and any partial pixel is discarded.
REQ-029 Byte packing: with SWAP_BYTES=0 the first byte goes to the MSB; with SWAP_BYTES=1 the first byte goes to the LSB; with BYTES_PER_PIXEL=1 the byte is passed through.
REQ-030 A pixel completes on the edge that samples its last byte; pixel_valid_out SHALL be high on the next cycle only (1-cycle latency).
REQ-031 Column counter: increments per completed pixel; clears on the href_in falling edge (href_in high on the previous cycle, low on this cycle).
REQ-032 Line end = href_in falling edge while in ROW_CAPTURE: line_done_out pulses on the next cycle and the row counter increments.
REQ-033 Decimation: a completed pixel is emitted only if col%DECIM==0 and row%DECIM==0; pixel_x_out = col/DECIM; pixel_y_out = row/DECIM.
REQ-034 Pixels with col>=H_ACTIVE, and all pixels on lines with row>=V_ACTIVE, SHALL NOT be emitted.
REQ-035 frame_error_out SHALL be set, and remain set (sticky) for the frame, if any line ends with column count != H_ACTIVE, or if the frame ends with row count != V_ACTIVE.
REQ-036 frame_error_out SHALL be valid in the same cycle as frame_done_out.
REQ-037 If vsync_in rises while href_in=1, the line SHALL be treated as ended (line_done_out pulses and the length check applies), then the frame ends.
REQ-038 Outside ROW_CAPTURE, pixel_valid_out and line_done_out SHALL stay 0.

Reset
REQ-039 While rst_n_in=0 at a rising edge: state -> IDLE; all counters -> 0; every output -> 0, including pixel_data_out, frame_count_out and busy_out.
REQ-040 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL require capture_en_in and a new vsync_in high before capturing again.

Verification
REQ-041 The bench SHALL cover these directed scenarios:
- BPP=2, H=4, V=2, DECIM=1, SWAP=0; bytes 0x12,0x34 -> pixel_data_out=0x1234 at x=0,y=0; 8 valids total; frame_done_out=1, frame_error_out=0, frame_count_out=1.
- Same stimulus with SWAP=1 -> first pixel 0x3412.
- DECIM=2, H=4, V=4 -> 4 valids, at (x,y) = (0,0), (1,0), (0,1), (1,1).
- Line of 5 pixels with H=4 -> 4 pixels emitted; frame_error_out=1 at frame_done_out; frame_error_out clears at the next frame start.
- capture_en_in dropped mid-frame -> frame completes, frame_count_out+1, busy_out=0 afterwards, no further valids.
- rst_n_in=0 for 1 cycle mid-line -> all outputs 0; a vsync_in low without prior ARM produces no valids.

Source files
------------

// File: rtl/camera_capture.sv
// Camera capture front end: assembles DVP-style byte streams into pixels, tags them
// with decimated coordinates and checks each frame's geometry against H_ACTIVE x V_ACTIVE.
module camera_capture #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int DECIM           = 1,
    parameter int SWAP_BYTES      = 0,
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic                         p_clock_in,
    input  logic                         rst_n_in,
    input  logic                         capture_en_in,
    input  logic                         vsync_in,
    input  logic                         href_in,
    input  logic [7:0]                   p_data_in,
    output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
    output logic                         pixel_valid_out,
    output logic [XW-1:0]                pixel_x_out,
    output logic [YW-1:0]                pixel_y_out,
    output logic                         line_done_out,
    output logic                         frame_done_out,
    output logic                         frame_error_out,
    output logic [15:0]                  frame_count_out,
    output logic                         busy_out,
    output logic [1:0]                   state_dbg_out
);

    // Column/row counters carry one extra bit so overlong lines and frames stay
    // distinguishable from the expected size; they saturate one past it.
    localparam int CW  = XW + 1;
    localparam int RW  = YW + 1;
    localparam int PW  = 8 * BYTES_PER_PIXEL;
    localparam int DSH = (DECIM > 1) ? $clog2(DECIM) : 0;

    localparam logic [CW-1:0] H_CNT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SAT    = CW'(H_ACTIVE + 1);
    localparam logic [CW-1:0] COL_MASK = CW'(DECIM - 1);
    localparam logic [RW-1:0] V_CNT    = RW'(V_ACTIVE);
    localparam logic [RW-1:0] V_SAT    = RW'(V_ACTIVE + 1);
    localparam logic [RW-1:0] ROW_MASK = RW'(DECIM - 1);
    localparam logic          LAST_BYTE = (BYTES_PER_PIXEL == 2);

    typedef enum logic [1:0] {
        S_IDLE             = 2'd0,
        S_ARM              = 2'd1,
        S_WAIT_FRAME_START = 2'd2,
        S_ROW_CAPTURE      = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            href_q;
    logic            byte_cnt_q;
    logic [7:0]      byte0_q;
    logic [CW-1:0]   col_cnt_q;
    logic [RW-1:0]   row_cnt_q;
    logic [PW-1:0]   pix_word;

    logic            in_row;
    logic            pix_done;
    logic            line_end;
    logic            frame_end;
    logic            start_frame;
    logic            line_bad;
    logic            emit;
    logic [RW-1:0]   row_inc;
    logic [RW-1:0]   row_final;

    generate
        if (BYTES_PER_PIXEL == 1) begin : g_bpp1
            assign pix_word = p_data_in;
        end else if (SWAP_BYTES != 0) begin : g_swap
            assign pix_word = {p_data_in, byte0_q};
        end else begin : g_noswap
            assign pix_word = {byte0_q, p_data_in};
        end
    endgenerate

    // A vsync rise with href still high closes the line in the same cycle as the frame.
    assign in_row      = (state_q == S_ROW_CAPTURE);
    assign pix_done    = in_row && href_in && !vsync_in && (byte_cnt_q == LAST_BYTE);
    assign line_end    = in_row && ((href_q && !href_in) || (vsync_in && href_in));
    assign frame_end   = in_row && vsync_in;
    assign start_frame = (state_q == S_WAIT_FRAME_START) && !vsync_in;
    assign line_bad    = line_end && (col_cnt_q != H_CNT);
    assign row_inc     = (row_cnt_q == V_SAT) ? row_cnt_q : row_cnt_q + RW'(1);
    assign row_final   = line_end ? row_inc : row_cnt_q;
    assign emit        = pix_done
                         && (col_cnt_q < H_CNT) && (row_cnt_q < V_CNT)
                         && ((col_cnt_q & COL_MASK) == '0)
                         && ((row_cnt_q & ROW_MASK) == '0);

    assign busy_out      = (state_q != S_IDLE);
    assign state_dbg_out = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:             if (capture_en_in) state_d = S_ARM;
            S_ARM:              if (vsync_in)      state_d = S_WAIT_FRAME_START;
            S_WAIT_FRAME_START: if (!vsync_in)     state_d = S_ROW_CAPTURE;
            S_ROW_CAPTURE: begin
                if (vsync_in) state_d = capture_en_in ? S_WAIT_FRAME_START : S_IDLE;
            end
            default:            state_d = S_IDLE;
        endcase
    end

    // pixel_valid_out is a one-cycle strobe with no back-pressure: pixel_data_out,
    // pixel_x_out and pixel_y_out are meaningful only in the cycle it is high.
    always_ff @(posedge p_clock_in) begin
        if (!rst_n_in) begin
            state_q         <= S_IDLE;
            href_q          <= 1'b0;
            byte_cnt_q      <= 1'b0;
            byte0_q         <= '0;
            col_cnt_q       <= '0;
            row_cnt_q       <= '0;
            pixel_data_out  <= '0;
            pixel_valid_out <= 1'b0;
            pixel_x_out     <= '0;
            pixel_y_out     <= '0;
            line_done_out   <= 1'b0;
            frame_done_out  <= 1'b0;
            frame_error_out <= 1'b0;
            frame_count_out <= '0;
        end else begin
            state_q         <= state_d;
            href_q          <= in_row && href_in;
            pixel_valid_out <= emit;
            line_done_out   <= line_end;
            frame_done_out  <= frame_end;

            if (emit) begin
                pixel_data_out <= pix_word;
                pixel_x_out    <= XW'(col_cnt_q >> DSH);
                pixel_y_out    <= YW'(row_cnt_q >> DSH);
            end

            if (in_row) begin
                if (href_in && !vsync_in) begin
                    byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? 1'b0 : 1'b1;
                    if (byte_cnt_q == 1'b0) byte0_q <= p_data_in;
                end else begin
                    byte_cnt_q <= 1'b0;
                end

                if (line_end)
                    col_cnt_q <= '0;
                else if (pix_done && (col_cnt_q != H_SAT))
                    col_cnt_q <= col_cnt_q + CW'(1);

                row_cnt_q <= row_final;

                if (line_bad || (frame_end && (row_final != V_CNT)))
                    frame_error_out <= 1'b1;
            end else begin
                byte_cnt_q <= 1'b0;
                col_cnt_q  <= '0;
                row_cnt_q  <= '0;
            end

            if (start_frame)
                frame_error_out <= 1'b0;

            if (frame_end)
                frame_count_out <= frame_count_out + 16'd1;
        end
    end

endmodule
